// File: rtl/uart_ctrl_pkg.sv
// rtl/uart_ctrl_pkg.sv - shared widths and FSM state types for the UART command sequencer
//   CMD_W      : assembled command width (opcode[23:16], data[15:0])
//   RESP_W     : response payload width
//   rx_state_t : command assembly states
//   tx_state_t : response serialiser states
package uart_ctrl_pkg;

  localparam int CMD_W  = 24;
  localparam int RESP_W = 16;

  typedef enum logic [1:0] {
    RX_B0,
    RX_B1,
    RX_B2,
    RX_HOLD
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_HI,
    TX_WAIT_HI,
    TX_LO,
    TX_WAIT_LO
  } tx_state_t;

endpackage

// File: rtl/uart_resp_tx.sv
// rtl/uart_resp_tx.sv - serialises a 1- or 2-byte response through the UART transmitter
//   clk, rst      : clock, synchronous active-high reset
//   send_resp     : start request, honoured only while idle
//   resp          : response payload, latched on send_resp
//   resp_len      : 0 = resp[7:0] only, 1 = resp[15:8] then resp[7:0]
//   tx_done       : UART transmit complete level
//   trmt          : one-cycle UART transmit start
//   tx_data       : byte presented to the UART, held until the next load
//   tx_busy       : sequencer not idle
//   resp_sent     : one-cycle pulse once the last byte has completed
module uart_resp_tx
  import uart_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              send_resp,
  input  logic [RESP_W-1:0] resp,
  input  logic              resp_len,
  input  logic              tx_done,
  output logic              trmt,
  output logic [7:0]        tx_data,
  output logic              tx_busy,
  output logic              resp_sent
);

  tx_state_t         state, state_n;
  logic [RESP_W-1:0] payload;
  logic              tx_done_q;
  logic              done_rise;

  // Only a fresh rising edge completes a byte; a level left high from an
  // earlier frame must not advance the sequencer.
  assign done_rise = tx_done & ~tx_done_q;
  assign tx_busy   = (state != TX_IDLE);

  always_comb begin
    state_n = state;
    case (state)
      TX_IDLE:    if (send_resp) state_n = resp_len ? TX_HI : TX_LO;
      TX_HI:      state_n = TX_WAIT_HI;
      TX_WAIT_HI: if (done_rise) state_n = TX_LO;
      TX_LO:      state_n = TX_WAIT_LO;
      TX_WAIT_LO: if (done_rise) state_n = TX_IDLE;
      default:    state_n = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= TX_IDLE;
      payload   <= '0;
      tx_done_q <= 1'b0;
      trmt      <= 1'b0;
      tx_data   <= 8'h00;
      resp_sent <= 1'b0;
    end else begin
      state     <= state_n;
      tx_done_q <= tx_done;
      trmt      <= (state == TX_HI) || (state == TX_LO);
      resp_sent <= (state == TX_WAIT_LO) && done_rise;
      if ((state == TX_IDLE) && send_resp) payload <= resp;
      if (state == TX_HI) tx_data <= payload[15:8];
      if (state == TX_LO) tx_data <= payload[7:0];
    end
  end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// rtl/uart_cmd_ctrl.sv - assembles 3-byte UART commands and sequences UART responses
//   clk, rst      : clock, synchronous active-high reset
//   rdy, rx_data  : UART received byte and its valid flag
//   clr_rdy       : one-cycle acknowledge of a received byte
//   trmt, tx_data : UART transmit start pulse and byte
//   tx_done       : UART transmit complete level
//   cmd_rdy, cmd  : completed command {opcode, data}, held until clr_cmd_rdy
//   clr_cmd_rdy   : host has consumed cmd
//   send_resp, resp, resp_len : response request, payload and length
//   tx_busy, resp_sent        : response sequencer status
//   frame_err     : one-cycle pulse when a partial command times out
module uart_cmd_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2**20,
  parameter int TO_W           = $clog2(TIMEOUT_CYCLES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [7:0]        rx_data,
  output logic              clr_rdy,
  output logic              trmt,
  output logic [7:0]        tx_data,
  input  logic              tx_done,
  output logic              cmd_rdy,
  output logic [CMD_W-1:0]  cmd,
  input  logic              clr_cmd_rdy,
  input  logic              send_resp,
  input  logic [RESP_W-1:0] resp,
  input  logic              resp_len,
  output logic              tx_busy,
  output logic              resp_sent,
  output logic              frame_err
);

  rx_state_t    state, state_n;
  logic [15:0]  partial;
  logic [TO_W-1:0] to_cnt;
  logic         accept;
  logic         timeout;
  logic         counting;

  assign counting = (state == RX_B1) || (state == RX_B2);

  // The ~clr_rdy term blocks a second capture of the same byte during the
  // cycle in which the UART is still clearing rdy.
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    timeout = 1'b0;
    case (state)
      RX_B0: begin
        if (rdy && !clr_rdy) begin
          accept  = 1'b1;
          state_n = RX_B1;
        end
      end
      RX_B1, RX_B2: begin
        if (rdy && !clr_rdy) begin
          accept  = 1'b1;
          state_n = (state == RX_B1) ? RX_B2 : RX_HOLD;
        end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
          timeout = 1'b1;
          state_n = RX_B0;
        end
      end
      RX_HOLD: begin
        // cmd_rdy is always set in this state, so clr_cmd_rdy alone suffices.
        if (clr_cmd_rdy) state_n = RX_B0;
      end
      default: state_n = RX_B0;
    endcase
  end

  // The first two bytes are staged in partial so a timed-out frame never
  // disturbs the last completed cmd.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RX_B0;
      partial   <= 16'h0000;
      cmd       <= '0;
      to_cnt    <= '0;
      clr_rdy   <= 1'b0;
      cmd_rdy   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      clr_rdy   <= accept;
      frame_err <= timeout;

      if (accept || timeout || !counting) to_cnt <= '0;
      else                                to_cnt <= to_cnt + TO_W'(1);

      if (accept) begin
        case (state)
          RX_B0:   partial[15:8] <= rx_data;
          RX_B1:   partial[7:0]  <= rx_data;
          RX_B2: begin
            cmd     <= {partial, rx_data};
            cmd_rdy <= 1'b1;
          end
          default: ;
        endcase
      end

      if ((state == RX_HOLD) && clr_cmd_rdy) cmd_rdy <= 1'b0;
    end
  end

  uart_resp_tx u_resp_tx (
    .clk       (clk),
    .rst       (rst),
    .send_resp (send_resp),
    .resp      (resp),
    .resp_len  (resp_len),
    .tx_done   (tx_done),
    .trmt      (trmt),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .resp_sent (resp_sent)
  );

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb/tb_uart_cmd_ctrl.sv - self-checking bench for uart_cmd_ctrl with a behavioural UART
module tb_uart_cmd_ctrl;

  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst, rdy, clr_rdy, trmt, tx_done, cmd_rdy, clr_cmd_rdy;
  logic        send_resp, resp_len, tx_busy, resp_sent, frame_err;
  logic [7:0]  rx_data, tx_data;
  logic [23:0] cmd;
  logic [15:0] resp;

  always #5 clk = ~clk;

  uart_cmd_ctrl #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .rdy         (rdy),
    .rx_data     (rx_data),
    .clr_rdy     (clr_rdy),
    .trmt        (trmt),
    .tx_data     (tx_data),
    .tx_done     (tx_done),
    .cmd_rdy     (cmd_rdy),
    .cmd         (cmd),
    .clr_cmd_rdy (clr_cmd_rdy),
    .send_resp   (send_resp),
    .resp        (resp),
    .resp_len    (resp_len),
    .tx_busy     (tx_busy),
    .resp_sent   (resp_sent),
    .frame_err   (frame_err)
  );

  typedef struct {
    logic [23:0] bytes;
    logic [23:0] exp;
  } cmd_vec_t;

  typedef struct {
    logic [15:0] r;
    logic        len;
  } resp_vec_t;

  int checks = 0;
  int passes = 0;
  int n_clr_rdy = 0, n_trmt = 0, n_resp_sent = 0, n_frame_err = 0;
  logic [23:0] cmd_q[$];
  logic [7:0]  byte_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    checks++;
    $display("FAIL %s: bounded wait expired", name);
  endtask

  // Monitor: counts pulses and pops scoreboards as the DUT produces results.
  initial begin
    logic prev_cmd_rdy;
    prev_cmd_rdy = 1'b0;
    forever begin
      @(negedge clk);
      if (clr_rdy)   n_clr_rdy++;
      if (frame_err) n_frame_err++;
      if (resp_sent) n_resp_sent++;
      if (trmt) begin
        n_trmt++;
        if (byte_q.size() == 0) begin
          checks++;
          $display("FAIL trmt_unexpected: tx_data %h with no byte expected", tx_data);
        end else check("tx_byte", {24'h0, tx_data}, {24'h0, byte_q.pop_front()});
      end
      if (cmd_rdy && !prev_cmd_rdy) begin
        if (cmd_q.size() == 0) begin
          checks++;
          $display("FAIL cmd_unexpected: cmd %h with none expected", cmd);
        end else check("cmd_value", {8'h0, cmd}, {8'h0, cmd_q.pop_front()});
      end
      prev_cmd_rdy = cmd_rdy;
    end
  end

  // UART transmitter model: tx_done drops on trmt and rises 8 cycles later.
  initial begin
    tx_done = 1'b1;
    forever begin
      @(negedge clk);
      if (trmt) begin
        tx_done = 1'b0;
        repeat (8) @(negedge clk);
        tx_done = 1'b1;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bit got;
    got = 1'b0;
    @(negedge clk);
    rx_data = b;
    rdy     = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (clr_rdy) got = 1'b1;
    end
    if (!got) fail_now("clr_rdy_wait");
    rdy = 1'b0;
  endtask

  task automatic send_cmd(input logic [23:0] b);
    send_byte(b[23:16]);
    send_byte(b[15:8]);
    send_byte(b[7:0]);
  endtask

  task automatic wait_cmd();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      if (cmd_rdy) got = 1'b1;
      else @(negedge clk);
    end
    if (!got) fail_now("cmd_rdy_wait");
  endtask

  task automatic pulse_clr_cmd();
    @(negedge clk);
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    check("cmd_rdy_cleared", {31'h0, cmd_rdy}, 32'h0);
  endtask

  task automatic do_resp(input logic [15:0] r, input logic len);
    int  t0, s0;
    bit  seen;
    t0   = n_trmt;
    s0   = n_resp_sent;
    seen = 1'b0;
    @(negedge clk);
    resp      = r;
    resp_len  = len;
    send_resp = 1'b1;
    if (len) byte_q.push_back(r[15:8]);
    byte_q.push_back(r[7:0]);
    @(negedge clk);
    send_resp = 1'b0;
    check("tx_busy_after_send", {31'h0, tx_busy}, 32'h1);
    check("trmt_not_yet", {31'h0, trmt}, 32'h0);
    @(negedge clk);
    check("trmt_latency", {31'h0, trmt}, 32'h1);
    // Request while busy must be dropped, not queued.
    @(negedge clk);
    resp      = ~r;
    resp_len  = ~len;
    send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (resp_sent) begin
        seen = 1'b1;
        check("tx_busy_at_resp_sent", {31'h0, tx_busy}, 32'h0);
      end
    end
    if (!seen) fail_now("resp_sent_wait");
    repeat (12) @(negedge clk);
    check("resp_sent_count", n_resp_sent - s0, 1);
    check("trmt_count", n_trmt - t0, len ? 2 : 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cmd_rdy"},   {31'h0, cmd_rdy},   32'h0);
    check({tag, "_cmd"},       {8'h0, cmd},        32'h0);
    check({tag, "_clr_rdy"},   {31'h0, clr_rdy},   32'h0);
    check({tag, "_trmt"},      {31'h0, trmt},      32'h0);
    check({tag, "_tx_data"},   {24'h0, tx_data},   32'h0);
    check({tag, "_tx_busy"},   {31'h0, tx_busy},   32'h0);
    check({tag, "_resp_sent"}, {31'h0, resp_sent}, 32'h0);
    check({tag, "_frame_err"}, {31'h0, frame_err}, 32'h0);
  endtask

  cmd_vec_t  cvec[4];
  resp_vec_t rvec[4];

  initial begin
    int base, fe, t0, s0;
    bit got;

    cvec[0] = '{24'hA51234, 24'hA51234};
    cvec[1] = '{24'h000000, 24'h000000};
    cvec[2] = '{24'hFFFFFF, 24'hFFFFFF};
    cvec[3] = '{24'h80017F, 24'h80017F};
    rvec[0] = '{16'hBEEF, 1'b1};
    rvec[1] = '{16'h1234, 1'b0};
    rvec[2] = '{16'h00FF, 1'b1};
    rvec[3] = '{16'hA5C3, 1'b0};

    rst = 1'b1; rdy = 1'b0; rx_data = 8'h00; clr_cmd_rdy = 1'b0;
    send_resp = 1'b0; resp = 16'h0; resp_len = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Table-driven command assembly.
    for (int i = 0; i < 4; i++) begin
      base = n_clr_rdy;
      fe   = n_frame_err;
      cmd_q.push_back(cvec[i].exp);
      send_cmd(cvec[i].bytes);
      wait_cmd();
      @(negedge clk);
      check("clr_rdy_per_cmd", n_clr_rdy - base, 3);
      check("no_frame_err", n_frame_err - fe, 0);
      pulse_clr_cmd();
    end

    // Held command: a pending byte must wait until the host clears cmd_rdy.
    cmd_q.push_back(24'hA51234);
    send_cmd(24'hA51234);
    wait_cmd();
    @(negedge clk);
    base    = n_clr_rdy;
    rx_data = 8'h00;
    rdy     = 1'b1;
    repeat (20) @(negedge clk);
    check("hold_cmd_stable", {8'h0, cmd}, 32'h00A51234);
    check("hold_cmd_rdy", {31'h0, cmd_rdy}, 32'h1);
    check("hold_no_clr_rdy", n_clr_rdy - base, 0);
    cmd_q.push_back(24'h00FF01);
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    check("hold_release", {31'h0, cmd_rdy}, 32'h0);
    @(negedge clk);
    check("pending_accepted", {31'h0, clr_rdy}, 32'h1);
    rdy = 1'b0;
    send_byte(8'hFF);
    send_byte(8'h01);
    wait_cmd();
    pulse_clr_cmd();

    // Inter-byte timeout.
    fe = n_frame_err;
    send_byte(8'h7E);
    repeat (50) @(negedge clk);
    check("no_early_timeout", n_frame_err - fe, 0);
    repeat (20) @(negedge clk);
    check("timeout_frame_err", n_frame_err - fe, 1);
    check("timeout_no_cmd_rdy", {31'h0, cmd_rdy}, 32'h0);
    check("timeout_cmd_kept", {8'h0, cmd}, 32'h0000FF01);
    cmd_q.push_back(24'h010203);
    send_cmd(24'h010203);
    wait_cmd();
    pulse_clr_cmd();

    // clr_cmd_rdy mid-frame is ignored.
    cmd_q.push_back(24'hC35A96);
    send_byte(8'hC3);
    @(negedge clk); clr_cmd_rdy = 1'b1;
    @(negedge clk); clr_cmd_rdy = 1'b0;
    send_byte(8'h5A);
    send_byte(8'h96);
    wait_cmd();
    pulse_clr_cmd();

    // Table-driven responses.
    for (int i = 0; i < 4; i++) do_resp(rvec[i].r, rvec[i].len);

    // Simultaneous command receive and response transmit.
    cmd_q.push_back(24'h424344);
    fork
      begin send_cmd(24'h424344); wait_cmd(); end
      do_resp(16'hC0DE, 1'b1);
    join
    pulse_clr_cmd();

    // Reset while waiting on the only byte of a response.
    t0 = n_trmt;
    @(negedge clk);
    resp = 16'h1234; resp_len = 1'b0; send_resp = 1'b1;
    byte_q.push_back(8'h34);
    @(negedge clk);
    send_resp = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (n_trmt != t0) got = 1'b1;
    end
    if (!got) fail_now("trmt_wait");
    repeat (3) @(negedge clk);
    check("in_wait_lo_busy", {31'h0, tx_busy}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("tx_reset");
    t0 = n_trmt;
    s0 = n_resp_sent;
    repeat (30) @(negedge clk);
    check("no_trmt_after_reset", n_trmt - t0, 0);
    check("no_resp_sent_after_reset", n_resp_sent - s0, 0);

    // Reset after two command bytes abandons the partial frame.
    send_byte(8'hA1);
    send_byte(8'hB2);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    repeat (10) @(negedge clk);
    check("partial_reset_cmd_rdy", {31'h0, cmd_rdy}, 32'h0);
    check("partial_reset_cmd", {8'h0, cmd}, 32'h0);
    cmd_q.push_back(24'h112233);
    send_cmd(24'h112233);
    wait_cmd();
    pulse_clr_cmd();

    repeat (5) @(negedge clk);
    check("cmd_queue_drained", cmd_q.size(), 0);
    check("byte_queue_drained", byte_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
